// File: rtl/traffic_pkg.sv
// Shared types and constants for the crossroads traffic-light controller.
package traffic_pkg;

  // Phase sequencer states; NIGHT overrides the normal four-phase cycle.
  typedef enum logic [2:0] {
    EWG   = 3'd0,
    EWY   = 3'd1,
    SNG   = 3'd2,
    SNY   = 3'd3,
    NIGHT = 3'd4
  } state_t;

  // Lamp encoding {red, yellow, green}, active-high.
  localparam logic [2:0] LED_R   = 3'b100;
  localparam logic [2:0] LED_Y   = 3'b010;
  localparam logic [2:0] LED_G   = 3'b001;
  localparam logic [2:0] LED_OFF = 3'b000;

  // Width of the countdown values sent to the seven-segment driver.
  localparam int TIME_W = 6;

endpackage

// File: rtl/tick_gen.sv
// One-second time base: a single-cycle pulse every TICK_CNT sys_clk cycles.
// clr restarts the count so a new phase gets a full first second.
module tick_gen
  import traffic_pkg::*;
#(
  parameter int TICK_CNT = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_CNT > 2) ? $clog2(TICK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT - 1);

  logic [CNT_W-1:0] tick_cnt;

  assign tick = (tick_cnt == CNT_LAST);

  // Free-running 0..TICK_CNT-1 counter; clear wins over the wrap.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Crossroads phase sequencer: EW/SN green-yellow cycle on a 1 s time base,
// lamp drive, countdown values for the display, and a flashing-yellow
// night override with the display blanked.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_CNT    = 50_000_000,
  parameter int GREEN_TIME  = 27,
  parameter int YELLOW_TIME = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              night,
  output logic [TIME_W-1:0] ew_time,
  output logic [TIME_W-1:0] sn_time,
  output logic              en,
  output logic [2:0]        ew_led,
  output logic [2:0]        sn_led
);

  localparam logic [TIME_W-1:0] GREEN_T  = TIME_W'(GREEN_TIME);
  localparam logic [TIME_W-1:0] YELLOW_T = TIME_W'(YELLOW_TIME);

  state_t            state_p0, state_d;
  logic [TIME_W-1:0] sec_cnt_p0, sec_cnt_d;
  logic              flash_p0, flash_d;
  logic              tick;
  logic              clr;

  logic [2:0]        ew_led_d, sn_led_d;
  logic [TIME_W-1:0] ew_time_d, sn_time_d;
  logic              vld_d;

  logic [2:0]        ew_led_p1, sn_led_p1;
  logic [TIME_W-1:0] ew_time_p1, sn_time_p1;
  logic              vld_p1;

  // Restart the second count on every transition into or out of NIGHT.
  assign clr = (state_p0 == NIGHT) ? !night : night;

  tick_gen #(
    .TICK_CNT(TICK_CNT)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (clr),
    .tick     (tick)
  );

  // Stage p0: phase state, seconds remaining and night flash phase.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_p0   <= EWG;
      sec_cnt_p0 <= GREEN_T;
      flash_p0   <= 1'b0;
    end else begin
      state_p0   <= state_d;
      sec_cnt_p0 <= sec_cnt_d;
      flash_p0   <= flash_d;
    end
  end

  // Next phase: night request beats a coincident tick; otherwise count down and reload.
  always_comb begin
    state_d   = state_p0;
    sec_cnt_d = sec_cnt_p0;
    flash_d   = flash_p0;
    if (state_p0 == NIGHT) begin
      if (!night) begin
        state_d   = EWG;
        sec_cnt_d = GREEN_T;
      end else if (tick) begin
        flash_d = !flash_p0;
      end
    end else if (night) begin
      state_d = NIGHT;
      flash_d = 1'b1;
    end else if (tick) begin
      if (sec_cnt_p0 > TIME_W'(1)) begin
        sec_cnt_d = sec_cnt_p0 - 1'b1;
      end else begin
        case (state_p0)
          EWG: begin
            state_d   = EWY;
            sec_cnt_d = YELLOW_T;
          end
          EWY: begin
            state_d   = SNG;
            sec_cnt_d = GREEN_T;
          end
          SNG: begin
            state_d   = SNY;
            sec_cnt_d = YELLOW_T;
          end
          SNY: begin
            state_d   = EWG;
            sec_cnt_d = GREEN_T;
          end
          default: begin
            state_d   = EWG;
            sec_cnt_d = GREEN_T;
          end
        endcase
      end
    end
  end

  // Lamp and countdown mapping; the red side shows the time until its own green.
  always_comb begin
    ew_led_d  = LED_OFF;
    sn_led_d  = LED_OFF;
    ew_time_d = '0;
    sn_time_d = '0;
    vld_d     = 1'b0;
    case (state_p0)
      EWG: begin
        ew_led_d  = LED_G;
        sn_led_d  = LED_R;
        ew_time_d = sec_cnt_p0;
        sn_time_d = sec_cnt_p0 + YELLOW_T;
        vld_d     = 1'b1;
      end
      EWY: begin
        ew_led_d  = LED_Y;
        sn_led_d  = LED_R;
        ew_time_d = sec_cnt_p0;
        sn_time_d = sec_cnt_p0;
        vld_d     = 1'b1;
      end
      SNG: begin
        ew_led_d  = LED_R;
        sn_led_d  = LED_G;
        ew_time_d = sec_cnt_p0 + YELLOW_T;
        sn_time_d = sec_cnt_p0;
        vld_d     = 1'b1;
      end
      SNY: begin
        ew_led_d  = LED_R;
        sn_led_d  = LED_Y;
        ew_time_d = sec_cnt_p0;
        sn_time_d = sec_cnt_p0;
        vld_d     = 1'b1;
      end
      NIGHT: begin
        ew_led_d = {1'b0, flash_p0, 1'b0};
        sn_led_d = {1'b0, flash_p0, 1'b0};
      end
      default: begin
        ew_led_d = LED_OFF;
        sn_led_d = LED_OFF;
      end
    endcase
  end

  // Stage p1: registered outputs, one cycle behind the phase state.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ew_led_p1  <= LED_OFF;
      sn_led_p1  <= LED_OFF;
      ew_time_p1 <= '0;
      sn_time_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      ew_led_p1  <= ew_led_d;
      sn_led_p1  <= sn_led_d;
      ew_time_p1 <= ew_time_d;
      sn_time_p1 <= sn_time_d;
      vld_p1     <= vld_d;
    end
  end

  assign ew_led  = ew_led_p1;
  assign sn_led  = sn_led_p1;
  assign ew_time = ew_time_p1;
  assign sn_time = sn_time_p1;
  assign en      = vld_p1;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Testbench for traffic_ctrl with a fast time base (10 cycles per second,
// 5 s green, 2 s yellow). Each scenario queues the expected output of every
// cycle it observes and compares as the DUT produces it.
module tb_traffic_ctrl;
  import traffic_pkg::*;

  localparam int TC = 10;
  localparam int G  = 5;
  localparam int Y  = 2;

  typedef struct packed {
    logic       en;
    logic [2:0] ew_led;
    logic [2:0] sn_led;
    logic [5:0] ew_time;
    logic [5:0] sn_time;
  } obs_t;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       night     = 1'b0;
  logic [5:0] ew_time, sn_time;
  logic       en;
  logic [2:0] ew_led, sn_led;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb[$];
  bit   inv_ok;

  traffic_ctrl #(
    .TICK_CNT   (TC),
    .GREEN_TIME (G),
    .YELLOW_TIME(Y)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .night    (night),
    .ew_time  (ew_time),
    .sn_time  (sn_time),
    .en       (en),
    .ew_led   (ew_led),
    .sn_led   (sn_led)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic obs_t mk(logic [2:0] e, logic [2:0] s, int et, int st, logic v);
    obs_t o;
    o.en      = v;
    o.ew_led  = e;
    o.sn_led  = s;
    o.ew_time = 6'(et);
    o.sn_time = 6'(st);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.en      = en;
    o.ew_led  = ew_led;
    o.sn_led  = sn_led;
    o.ew_time = ew_time;
    o.sn_time = sn_time;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("en=%b ew_led=%b sn_led=%b ew_time=%0d sn_time=%0d",
                     o.en, o.ew_led, o.sn_led, o.ew_time, o.sn_time);
  endfunction

  task automatic push_n(obs_t o, int n);
    repeat (n) sb.push_back(o);
  endtask

  // Expected outputs for one complete light cycle, starting at a fresh EWG.
  task automatic push_full_cycle();
    for (int s = G; s >= 1; s--) push_n(mk(LED_G, LED_R, s, s + Y, 1'b1), TC);
    for (int s = Y; s >= 1; s--) push_n(mk(LED_Y, LED_R, s, s, 1'b1), TC);
    for (int s = G; s >= 1; s--) push_n(mk(LED_R, LED_G, s + Y, s, 1'b1), TC);
    for (int s = Y; s >= 1; s--) push_n(mk(LED_R, LED_Y, s, s, 1'b1), TC);
  endtask

  // Reset for two edges; returns with reset released so the next edge is cycle 1.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    night     = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic skip(int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    obs_t exp_o, act_o;
    sb.delete();
    sys_rst_n = 1'b0;
    night     = 1'b0;
    push_n(mk(LED_OFF, LED_OFF, 0, 0, 1'b0), 5);
    sb.push_back(mk(LED_G, LED_R, G, G + Y, 1'b1));
    for (int c = -4; sb.size() > 0; c++) begin
      @(posedge sys_clk);
      #1;
      exp_o = sb.pop_front();
      act_o = sample();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL reset c=%0d got %s want %s", c, fmt(act_o), fmt(exp_o));
      end
      if (c == 0) sys_rst_n = 1'b1;
    end
  endtask

  task automatic test_full_cycle();
    obs_t exp_o, act_o;
    sb.delete();
    do_reset();
    push_full_cycle();
    sb.push_back(mk(LED_G, LED_R, G, G + Y, 1'b1));
    for (int c = 1; sb.size() > 0; c++) begin
      @(posedge sys_clk);
      #1;
      exp_o = sb.pop_front();
      act_o = sample();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL full_cycle c=%0d got %s want %s", c, fmt(act_o), fmt(exp_o));
      end
    end
  endtask

  task automatic test_phase_edge();
    obs_t exp_o, act_o;
    sb.delete();
    do_reset();
    skip(48);
    push_n(mk(LED_G, LED_R, 1, 1 + Y, 1'b1), 2);
    push_n(mk(LED_Y, LED_R, Y, Y, 1'b1), 2);
    for (int c = 49; sb.size() > 0; c++) begin
      @(posedge sys_clk);
      #1;
      exp_o = sb.pop_front();
      act_o = sample();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL phase_edge c=%0d got %s want %s", c, fmt(act_o), fmt(exp_o));
      end
    end
  endtask

  task automatic test_night();
    obs_t exp_o, act_o;
    sb.delete();
    do_reset();
    skip(74);
    push_n(mk(LED_R, LED_G, G + Y, G, 1'b1), 2);
    push_n(mk(LED_Y, LED_Y, 0, 0, 1'b0), TC);
    push_n(mk(LED_OFF, LED_OFF, 0, 0, 1'b0), TC);
    push_n(mk(LED_Y, LED_Y, 0, 0, 1'b0), 5);
    push_n(mk(LED_G, LED_R, G, G + Y, 1'b1), TC);
    sb.push_back(mk(LED_G, LED_R, G - 1, G - 1 + Y, 1'b1));
    for (int c = 75; sb.size() > 0; c++) begin
      @(posedge sys_clk);
      #1;
      exp_o = sb.pop_front();
      act_o = sample();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL night c=%0d got %s want %s", c, fmt(act_o), fmt(exp_o));
      end
      if (c == 75)  night = 1'b1;
      if (c == 100) night = 1'b0;
    end
  endtask

  task automatic test_tick_collision();
    obs_t exp_o, act_o;
    sb.delete();
    do_reset();
    skip(48);
    push_n(mk(LED_G, LED_R, 1, 1 + Y, 1'b1), 2);
    push_n(mk(LED_Y, LED_Y, 0, 0, 1'b0), 4);
    push_n(mk(LED_G, LED_R, G, G + Y, 1'b1), 2);
    for (int c = 49; sb.size() > 0; c++) begin
      @(posedge sys_clk);
      #1;
      exp_o = sb.pop_front();
      act_o = sample();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL tick_collision c=%0d got %s want %s", c, fmt(act_o), fmt(exp_o));
      end
      if (c == 49) night = 1'b1;
      if (c == 53) night = 1'b0;
    end
  endtask

  task automatic test_night_pulse();
    obs_t exp_o, act_o;
    sb.delete();
    do_reset();
    skip(19);
    sb.push_back(mk(LED_G, LED_R, G - 1, G - 1 + Y, 1'b1));
    sb.push_back(mk(LED_G, LED_R, G - 2, G - 2 + Y, 1'b1));
    sb.push_back(mk(LED_Y, LED_Y, 0, 0, 1'b0));
    push_n(mk(LED_G, LED_R, G, G + Y, 1'b1), TC);
    sb.push_back(mk(LED_G, LED_R, G - 1, G - 1 + Y, 1'b1));
    for (int c = 20; sb.size() > 0; c++) begin
      @(posedge sys_clk);
      #1;
      exp_o = sb.pop_front();
      act_o = sample();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL night_pulse c=%0d got %s want %s", c, fmt(act_o), fmt(exp_o));
      end
      if (c == 20) night = 1'b1;
      if (c == 21) night = 1'b0;
    end
  endtask

  task automatic test_reset_mid_phase();
    obs_t exp_o, act_o;
    sb.delete();
    do_reset();
    skip(124);
    sb.push_back(mk(LED_R, LED_Y, Y, Y, 1'b1));
    sb.push_back(mk(LED_OFF, LED_OFF, 0, 0, 1'b0));
    push_n(mk(LED_G, LED_R, G, G + Y, 1'b1), TC);
    sb.push_back(mk(LED_G, LED_R, G - 1, G - 1 + Y, 1'b1));
    for (int c = 125; sb.size() > 0; c++) begin
      @(posedge sys_clk);
      #1;
      exp_o = sb.pop_front();
      act_o = sample();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL reset_mid_phase c=%0d got %s want %s", c, fmt(act_o), fmt(exp_o));
      end
      if (c == 125) sys_rst_n = 1'b0;
      if (c == 126) sys_rst_n = 1'b1;
    end
  endtask

  // Lamp safety invariants, evaluated on every cycle away from the clock edge.
  always @(negedge sys_clk) begin
    inv_ok = !(ew_led[0] && sn_led[0]) && !(ew_led[0] && sn_led[1]) &&
             !(ew_led[1] && sn_led[0]);
    if (en) begin
      inv_ok = inv_ok && ($countones(ew_led) == 1) && ($countones(sn_led) == 1) &&
               (!(ew_led[0] || ew_led[1]) || (sn_led == LED_R)) &&
               (!(sn_led[0] || sn_led[1]) || (ew_led == LED_R));
    end else begin
      inv_ok = inv_ok && (ew_led == sn_led) && !ew_led[2] && !ew_led[0];
    end
    n_checks++;
    if (!inv_ok) begin
      n_fail++;
      $display("FAIL lamp_invariant t=%0t got en=%b ew_led=%b sn_led=%b want one lamp per side and red opposite green/yellow",
               $time, en, ew_led, sn_led);
    end
  end

  initial begin
    test_reset();
    test_full_cycle();
    test_phase_edge();
    test_night();
    test_tick_collision();
    test_night_pulse();
    test_reset_mid_phase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Phase sequencer for the crossroads traffic-light design. It runs the east-west/south-north light cycle from a 1 s time base and drives the red/yellow/green lamps. It also drives the countdown values and enable consumed by the 4-digit seven-segment display driver (`ew_time`, `sn_time`, `en`). A `night` input overrides the cycle with flashing yellow and a blanked display.

## Interface
- `TICK_CNT`, default 50_000_000: sys_clk cycles per 1 s tick (50 MHz). Must be ≥ 2.
- `GREEN_TIME`, default 27: green phase length, in seconds. Must be ≥ 1.
- `YELLOW_TIME`, default 3: yellow phase length, in seconds. Must be ≥ 1. `GREEN_TIME + YELLOW_TIME` must be ≤ 63.
- `sys_clk` in 1: system clock. One clock domain only.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `night` in 1: night mode request, level-sensitive, already synchronous to sys_clk.
- `ew_time` out 6: east-west countdown, in seconds.
- `sn_time` out 6: south-north countdown, in seconds.
- `en` out 1: display enable.
- `ew_led` out 3: east-west lamps, bit order {red, yellow, green}, active-high.
- `sn_led` out 3: south-north lamps, same encoding as `ew_led`.

## Operation
- **Tick generator**
  - `tick_cnt` counts 0..TICK_CNT-1 and wraps.
  - `tick` is asserted for one cycle when `tick_cnt == TICK_CNT-1`.
  - `tick_cnt` is cleared on every state entry from or into NIGHT.
- **States:** EWG, EWY, SNG, SNY, NIGHT.
- **Phase counter** `sec_cnt` (6 bit) holds the seconds remaining in the current phase.
- **Phase advance:** on `tick`, if `sec_cnt > 1`, decrement `sec_cnt`. Otherwise advance to the next state and load `sec_cnt` as follows:
  - EWG→EWY, load YELLOW_TIME.
  - EWY→SNG, load GREEN_TIME.
  - SNG→SNY, load YELLOW_TIME.
  - SNY→EWG, load GREEN_TIME.
- **Night entry:** `night`=1 in any non-NIGHT state moves to NIGHT on the next edge. This takes priority over a coincident `tick`. `flash` is set to 1.
- **In NIGHT:** `flash` toggles on each `tick`.
- **Night exit:** `night`=0 while in NIGHT moves to EWG with `sec_cnt`=GREEN_TIME.
- **Output mapping** (registered, computed from the current state and `sec_cnt`):
  - EWG: ew_led=001, sn_led=100, ew_time=sec_cnt, sn_time=sec_cnt+YELLOW_TIME, en=1.
  - EWY: ew_led=010, sn_led=100, ew_time=sec_cnt, sn_time=sec_cnt, en=1.
  - SNG: ew_led=100, sn_led=001, ew_time=sec_cnt+YELLOW_TIME, sn_time=sec_cnt, en=1.
  - SNY: ew_led=100, sn_led=010, ew_time=sec_cnt, sn_time=sec_cnt, en=1.
  - NIGHT: ew_led=sn_led={1'b0, flash, 1'b0}, ew_time=sn_time=0, en=0.
- **Invariants** (verify by assertion):
  - Exactly one lamp is lit per direction outside NIGHT.
  - Never both greens lit; never a green and a yellow lit across the two directions.
  - Red on one side holds for the whole green+yellow of the other side.

## Timing
- **Reset:** `sys_rst_n`=0 at a rising edge forces:
  - state=EWG, sec_cnt=GREEN_TIME, tick_cnt=0, flash=0;
  - all outputs to 0 (lamps off, en=0, times 0).
- **Reset mid-operation:** reset asserted in the middle of any phase or in NIGHT is handled identically to power-up reset.
- **After reset release:** on the first edge with `sys_rst_n`=1, outputs show EWG: ew_time=GREEN_TIME, sn_time=GREEN_TIME+YELLOW_TIME, ew_led=001, sn_led=100, en=1.
- **Output latency:** outputs lag state and `sec_cnt` by exactly one cycle.
- **Phase lengths:** the first tick arrives TICK_CNT cycles after reset release. Each phase lasts exactly its length × TICK_CNT cycles. The full cycle is 2·(GREEN_TIME+YELLOW_TIME)·TICK_CNT cycles.
- **Displayed count:** the displayed value never reaches 0 in normal phases; it counts N..1, then reloads.
- **Night response:** outputs reflect a `night` change two edges after `night` changes (state register, then output register). A one-cycle `night` pulse still causes a full NIGHT entry and exit, resuming at a fresh EWG.

## Structure
- **Package `traffic_pkg`:**
  - state enum (EWG, EWY, SNG, SNY, NIGHT);
  - lamp constants LED_R=3'b100, LED_Y=3'b010, LED_G=3'b001, LED_OFF=3'b000;
  - time width constant TIME_W=6.
- **Sub-module `tick_gen`:** parameter TICK_CNT; inputs sys_clk, sys_rst_n, clr; output tick (one-cycle pulse).
- **`traffic_ctrl`:** holds the FSM, `sec_cnt`, `flash`, and the output registers.

## Test plan
All scenarios use TICK_CNT=10, GREEN_TIME=5, YELLOW_TIME=2.
1. **Reset:** hold reset for 5 cycles → all outputs 0. Release → next edge shows ew_time=5, sn_time=7, ew_led=001, sn_led=100, en=1.
2. **Full cycle:** run 140 cycles with no night → expected sequence:
   - ew_time 5,4,3,2,1 (green), then 2,1 (yellow);
   - sn_time 7..1 in step;
   - then the mirror phase;
   - state returns to EWG at cycle 140 with the same outputs as cycle 0.
3. **Phase edge:** at the tick ending EWG (cycle 50) → within 1 cycle ew_led goes 001→010 and ew_time=sn_time=2. Both greens are never lit on any cycle.
4. **Night:** assert night mid-SNG → within 2 cycles en=0, times 0, both lamps 010. The lamps toggle 010/000 every 10 cycles. Deassert → restart at EWG with ew_time=5, sn_time=7.
5. **Tick collision:** assert night on the exact cycle of a phase-ending tick → enters NIGHT, with no intermediate phase visible on the outputs.
6. **Reset mid-phase:** pulse reset for 1 cycle during SNY → outputs 0 for that cycle, then the EWG start values. The first tick follows exactly 10 cycles later.
